// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store controller.
//   - RV32I load/store funct3 encodings
//   - controller state enum
//   - captured request struct
//   - accessSize(): funct3 -> access width in bytes
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE,
        LD_RD,
        RMW_RD,
        ST_WR,
        RESP
    } lsuState_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsuReq_t;

    // Width in bytes; the low two funct3 bits carry the size for both
    // signed and unsigned variants. Illegal encodings are caught elsewhere.
    function automatic logic [2:0] accessSize(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering for the load/store controller.
// Ports:
//   memWord    - word read from data memory
//   offset     - byte offset of the access within the word (addr[1:0])
//   funct3     - RV32I load/store funct3
//   storeData  - store data from the core (low byte/half used for SB/SH)
//   loadData   - extracted and sign/zero-extended load result
//   mergedWord - memWord with the store byte/half inserted at offset
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] memWord,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] storeData,
    output logic [31:0] loadData,
    output logic [31:0] mergedWord
);

    logic [4:0]  shamt;
    logic [31:0] shifted;

    always_comb begin
        shamt   = {offset, 3'b000};
        shifted = memWord >> shamt;

        case (funct3)
            F3_B:    loadData = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   loadData = {24'd0, shifted[7:0]};
            F3_H:    loadData = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   loadData = {16'd0, shifted[15:0]};
            default: loadData = memWord;
        endcase

        // Clear the target lane, then OR in the shifted store bytes.
        case (funct3[1:0])
            2'b00:   mergedWord = (memWord & ~(32'h0000_00FF << shamt))
                                | ({24'd0, storeData[7:0]} << shamt);
            2'b01:   mergedWord = (memWord & ~(32'h0000_FFFF << shamt))
                                | ({16'd0, storeData[15:0]} << shamt);
            default: mergedWord = storeData;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller between the core memory stage and a
// byte-addressed, word-ported data memory.
// Ports:
//   clk, rst_n                  - clock, synchronous active-low reset
//   req_valid_i / req_ready_o   - request handshake (accept on valid & ready)
//   req_we_i, req_funct3_i      - store flag and RV32I funct3
//   req_addr_i, req_wdata_i     - byte address and store data
//   resp_valid_o                - one-cycle completion pulse
//   resp_err_o                  - completion was an error (no memory touched)
//   resp_rdata_o                - extended load data, 0 for stores/errors
//   mem_addr_o                  - word-aligned memory address
//   mem_wdata_o                 - full word to write
//   mem_re_o, mem_we_o          - memory read / write strobes
//   mem_rdata_i                 - memory read word, valid by the next posedge
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic        resp_err_o,
    output logic [31:0] resp_rdata_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_re_o,
    output logic        mem_we_o,
    input  logic [31:0] mem_rdata_i
);

    lsuState_t   state;
    lsuReq_t     req;
    logic [31:0] wrWord;
    logic        accept;
    logic        accErr;
    logic [32:0] endAddr;
    logic [31:0] ldData;
    logic [31:0] mergedWord;

    // Strobes are gated by rst_n so a reset asserted mid-write never lands.
    assign req_ready_o = rst_n && (state == IDLE);
    assign mem_re_o    = rst_n && ((state == LD_RD) || (state == RMW_RD));
    assign mem_we_o    = rst_n && (state == ST_WR);
    assign mem_addr_o  = (state != IDLE) ? {req.addr[31:2], 2'b00} : 32'd0;
    assign mem_wdata_o = wrWord;
    assign accept      = req_valid_i && req_ready_o;

    // Error decode on the live request; 33-bit sum so addresses near
    // 2^32 cannot wrap into range.
    always_comb begin
        endAddr = {1'b0, req_addr_i} + 33'(accessSize(req_funct3_i));
        accErr  = 1'b0;
        case (req_funct3_i)
            F3_B, F3_BU: accErr = 1'b0;
            F3_H, F3_HU: accErr = req_addr_i[0];
            F3_W:        accErr = (req_addr_i[1:0] != 2'b00);
            default:     accErr = 1'b1;
        endcase
        if (req_we_i && req_funct3_i[2])
            accErr = 1'b1;
        if (endAddr > 33'(MEM_BYTES))
            accErr = 1'b1;
    end

    lsu_align uAlign (
        .memWord    (mem_rdata_i),
        .offset     (req.addr[1:0]),
        .funct3     (req.funct3),
        .storeData  (req.wdata),
        .loadData   (ldData),
        .mergedWord (mergedWord)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            req          <= '0;
            wrWord       <= '0;
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= '0;
        end else begin
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (accErr) begin
                            // Errors complete from IDLE without capturing.
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                        end else begin
                            req <= '{we: req_we_i, funct3: req_funct3_i,
                                     addr: req_addr_i, wdata: req_wdata_i};
                            wrWord <= req_wdata_i;
                            if (!req_we_i)
                                state <= LD_RD;
                            else if (req_funct3_i == F3_W)
                                state <= ST_WR;
                            else
                                state <= RMW_RD;
                        end
                    end
                end
                LD_RD: begin
                    resp_rdata_o <= ldData;
                    resp_valid_o <= 1'b1;
                    state        <= RESP;
                end
                RMW_RD: begin
                    wrWord <= mergedWord;
                    state  <= ST_WR;
                end
                ST_WR: begin
                    resp_valid_o <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store controller between the core's memory stage and the byte-addressed, word-ported data memory.
- Accepts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) and word-aligns the memory address.
- Sub-word stores run as read-modify-write sequences; loads are extracted and sign/zero-extended.
- Misaligned, out-of-range and illegal accesses are flagged as errors and never touch memory.

Parameters:
MEM_BYTES, 1024, data memory size in bytes; any access with addr+size > MEM_BYTES is an error.

Ports:
clk  input  1  clock; memory writes on posedge, memory reads on negedge
rst_n  input  1  synchronous active-low reset
req_valid_i  input  1  request present; held until accepted
req_ready_o  output  1  controller idle, request accepted at posedge when valid&ready
req_we_i  input  1  1 = store, 0 = load
req_funct3_i  input  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr_i  input  32  byte address
req_wdata_i  input  32  store data; low byte/half used for SB/SH
resp_valid_o  output  1  one-cycle completion pulse
resp_err_o  output  1  qualifies resp_valid_o: misaligned/out-of-range/illegal funct3
resp_rdata_o  output  32  extended load data; 0 for stores and errors
mem_addr_o  output  32  word-aligned address {addr[31:2],2'b00}
mem_wdata_o  output  32  full word to write
mem_re_o  output  1  read enable to data memory
mem_we_o  output  1  write enable to data memory
mem_rdata_i  input  32  word from data memory; valid before the posedge following the mem_re_o cycle

Behaviour:
- Reset (rst_n low at posedge): state IDLE, resp_valid_o/resp_err_o 0, resp_rdata_o 0, captured request cleared.
- mem_re_o and mem_we_o are combinationally forced 0 while rst_n is low, so reset mid-write never lands a write.
- req_ready_o = 1 only in IDLE and not in reset. The request is captured at accept; later input changes are ignored.
- Error check at accept:
  - H requires addr[0]=0; W requires addr[1:0]=0.
  - addr+size > MEM_BYTES is an error.
  - Loads accept funct3 000/001/010/100/101; stores accept 000/001/010. Anything else is an error.
  - On error: no state change and no memory strobe; next cycle resp_valid_o=1, resp_err_o=1, rdata 0.
- States (package enum): IDLE, LD_RD, RMW_RD, ST_WR, RESP.
- Load: IDLE -accept E0-> LD_RD.
  - LD_RD asserts mem_re_o for one cycle.
  - At E1: extract byte/half using addr[1:0], sign- or zero-extend, register into resp_rdata_o, go to RESP.
  - RESP: resp_valid_o=1 for one cycle, then IDLE. The next accept is possible at E3.
- SW: IDLE -E0-> ST_WR, which asserts mem_we_o with mem_wdata_o=wdata. Memory writes at E1; then RESP.
- SB/SH: IDLE -E0-> RMW_RD, which asserts mem_re_o.
  - At E1: merge the byte/half into the read word at lane addr[1:0]; register as write data; go to ST_WR.
  - ST_WR writes at E2; then RESP.
- mem_re_o and mem_we_o are never both 1. mem_addr_o holds the aligned captured address in all non-IDLE states, else 0.
- resp_err_o is 0 on every non-error response.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - State enum and width.
  - Size decode function (funct3 -> 1/2/4 bytes).
- One sub-module, lsu_align (combinational):
  - Load extract/extend from (word, offset, funct3).
  - Store merge from (old word, wdata, offset, funct3).

Test Plan:
- Preload bytes 0x10..0x13 = BB,AA,99,88. LW 0x10 -> mem_re_o one cycle; resp_valid_o two cycles after accept; rdata 0x8899AABB; err 0.
- LB 0x13 -> 0xFFFFFF88. LBU 0x13 -> 0x00000088. LH 0x12 -> 0xFFFF8899. LHU 0x10 -> 0x0000AABB.
- SB 0x11 wdata 0x12345677 -> one mem_re_o cycle, then one mem_we_o cycle with wdata 0x889977BB; resp three cycles after accept. Follow-up LW 0x10 -> 0x889977BB.
- SH 0x12 wdata 0x0000CAFE on the original word -> memory word 0xCAFEAABB. SW 0x20 wdata 0xDEADBEEF -> a single mem_we_o cycle; LW 0x20 returns it.
- Error cases, each giving resp_valid_o=1, resp_err_o=1, rdata 0, no mem strobe: LW 0x11; LH 0x13; LW 0x3FE; LW 0x400; load funct3 011; store funct3 100.
- Drive rst_n low during the ST_WR cycle of an SB -> mem_we_o 0 that cycle, memory unchanged, req_ready_o=1 the cycle after reset release. Requests held while busy are accepted exactly once.
